// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, controller states and instruction field offsets shared by the ALU controller
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_ANDI = 3'b100,
    OP_ORI  = 3'b101,
    OP_MOV  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WR2} state_t;
  localparam int OP_LSB  = 13;
  localparam int SWP_BIT = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: splits a latched instruction into opcode, register fields and control flags
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [15:0] instr,
  output op_t         op,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [7:0]  imm8,
  output logic        is_swp,
  output logic        uses_imm,
  output logic        two_write,
  output logic        is_illegal
);
  assign op         = op_t'(instr[OP_LSB +: 3]);
  assign rd         = instr[RD_LSB +: 4];
  assign rs         = instr[RS_LSB +: 4];
  assign rt         = instr[RT_LSB +: 4];
  assign imm8       = instr[7:0];
  assign is_swp     = op == OP_MOV && instr[SWP_BIT];
  assign uses_imm   = op == OP_ANDI || op == OP_ORI;
  assign two_write  = op == OP_MUL || op == OP_DIV || is_swp;
  assign is_illegal = op == OP_ILL;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: accepts instructions, drives the ALU from the register file and writes results back
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NREG   = 16,
  parameter int HI_REG = 15,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [AW-1:0]    rf_ra,
  output logic [AW-1:0]    rf_rb,
  input  logic [WIDTH-1:0] rf_da,
  input  logic [WIDTH-1:0] rf_db,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_r15,
  input  logic             alu_of,
  output logic             done,
  output logic             err,
  output logic             ovf
);
  state_t           state_q, state_d;
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] cap_q;
  logic             ovf_q;
  logic             bad;
  op_t              op;
  logic [3:0]       rd, rs, rt;
  logic [7:0]       imm8;
  logic             is_swp, uses_imm, two_write, is_illegal;

  alu_ctrl_dec u_dec (
    .instr      (ir_q),
    .op         (op),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm8       (imm8),
    .is_swp     (is_swp),
    .uses_imm   (uses_imm),
    .two_write  (two_write),
    .is_illegal (is_illegal)
  );

  assign instr_ready = rst_n && state_q == S_IDLE;
  assign ovf         = ovf_q;

  // next state, ALU operand routing and write-port mux
  always_comb begin
    state_d = state_q;
    rf_ra   = '0;
    rf_rb   = '0;
    alu_op  = '0;
    alu_a   = '0;
    alu_b   = '0;
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    done    = 1'b0;
    err     = 1'b0;
    bad     = 1'b0;
    if (state_q == S_IDLE) begin
      state_d = instr_valid ? S_EXEC : S_IDLE;
    end else if (state_q == S_EXEC) begin
      rf_ra   = AW'((uses_imm || is_swp) ? rd : rs);
      rf_rb   = AW'(rt);
      alu_op  = op;
      alu_a   = rf_da;
      alu_b   = uses_imm ? WIDTH'(imm8) : rf_db;
      bad     = is_illegal || (op == OP_DIV && rf_db == '0);
      rf_we   = !bad;
      rf_wa   = AW'(rd);
      rf_wd   = alu_out;
      err     = bad;
      done    = !bad && !two_write;
      state_d = (!bad && two_write) ? S_WR2 : S_IDLE;
    end else begin
      rf_we   = 1'b1;
      rf_wa   = is_swp ? AW'(rt) : AW'(HI_REG);
      rf_wd   = cap_q;
      done    = 1'b1;
      state_d = S_IDLE;
    end
  end

  // state, latched instruction, second-write value and sticky add carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid) ir_q <= instr;
      if (state_q == S_EXEC) cap_q <= is_swp ? rf_da : alu_r15;
      if (state_q == S_EXEC && op == OP_ADD) ovf_q <= alu_of;
      else if (done) ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed instructions checked cycle by cycle against an instruction-level model
module tb_alu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  rf_ra, rf_rb, rf_wa;
  logic [15:0] rf_da, rf_db, rf_wd, alu_a, alu_b, alu_out, alu_r15;
  logic        rf_we, alu_of, done, err, ovf;
  logic [2:0]  alu_op;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        dn;
    logic        er;
    logic        rdy;
    logic        ov;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic [15:0] rf[16];
  logic [15:0] mdl[16];
  logic        mdl_ovf = 1'b0;
  logic        chk_en = 1'b0;
  int          cmp_n = 0;
  int          bad_n = 0;
  logic [15:0] old15;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra       (rf_ra),
    .rf_rb       (rf_rb),
    .rf_da       (rf_da),
    .rf_db       (rf_db),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_r15     (alu_r15),
    .alu_of      (alu_of),
    .done        (done),
    .err         (err),
    .ovf         (ovf)
  );

  assign rf_da = rf[rf_ra];
  assign rf_db = rf[rf_rb];

  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  int          ap, aq, ar;
  logic [16:0] as;
  always_comb begin
    alu_out = '0;
    alu_r15 = '0;
    alu_of  = 1'b0;
    ap = int'($signed(alu_a)) * int'($signed(alu_b));
    aq = 0;
    ar = 0;
    as = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_b != 0) begin
      aq = int'($signed(alu_a)) / int'($signed(alu_b));
      ar = int'($signed(alu_a)) % int'($signed(alu_b));
    end
    case (alu_op)
      3'd0: {alu_of, alu_out} = as;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: begin alu_out = ap[15:0]; alu_r15 = ap[31:16]; end
      3'd3: begin alu_out = aq[15:0]; alu_r15 = ar[15:0]; end
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = alu_a | alu_b;
      3'd6: alu_out = alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic dn, input logic er, input logic rdy, input logic ov);
    exp_t e;
    e.we = we; e.wa = wa; e.wd = wd; e.dn = dn; e.er = er; e.rdy = rdy; e.ov = ov;
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      ce = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0, 0, 0, 1, mdl_ovf);
      chk("rf_we", rf_we, ce.we);
      if (ce.we) begin
        chk("rf_wa", rf_wa, ce.wa);
        chk("rf_wd", rf_wd, ce.wd);
      end
      chk("done", done, ce.dn);
      chk("err", err, ce.er);
      chk("instr_ready", instr_ready, ce.rdy);
      chk("ovf", ovf, ce.ov);
    end
  end

  task automatic setr(input int i, input logic [15:0] v);
    rf[i]  = v;
    mdl[i] = v;
  endtask

  task automatic issue(input logic [15:0] ins);
    logic [2:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [15:0] a, b, o, v;
    logic [16:0] s;
    int          p, dq, dr, bnd;
    @(posedge clk); #1;
    op = ins[15:13]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    a = mdl[rs]; b = mdl[rt]; o = mdl[rd];
    q.push_back(mk(0, 0, 0, 0, 0, 1, mdl_ovf));
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        q.push_back(mk(1, rd, s[15:0], 1, 0, 0, mdl_ovf));
        mdl[rd] = s[15:0]; mdl_ovf = s[16];
      end
      3'd1: begin
        v = a - b;
        q.push_back(mk(1, rd, v, 1, 0, 0, mdl_ovf));
        mdl[rd] = v; mdl_ovf = 1'b0;
      end
      3'd2: begin
        p = int'($signed(a)) * int'($signed(b));
        q.push_back(mk(1, rd, p[15:0], 0, 0, 0, mdl_ovf));
        q.push_back(mk(1, 15, p[31:16], 1, 0, 0, mdl_ovf));
        mdl[rd] = p[15:0]; mdl[15] = p[31:16]; mdl_ovf = 1'b0;
      end
      3'd3: begin
        if (b == 0) begin
          q.push_back(mk(0, 0, 0, 0, 1, 0, mdl_ovf));
        end else begin
          dq = int'($signed(a)) / int'($signed(b));
          dr = int'($signed(a)) % int'($signed(b));
          q.push_back(mk(1, rd, dq[15:0], 0, 0, 0, mdl_ovf));
          q.push_back(mk(1, 15, dr[15:0], 1, 0, 0, mdl_ovf));
          mdl[rd] = dq[15:0]; mdl[15] = dr[15:0]; mdl_ovf = 1'b0;
        end
      end
      3'd4, 3'd5: begin
        v = (op == 3'd4) ? (o & {8'h00, ins[7:0]}) : (o | {8'h00, ins[7:0]});
        q.push_back(mk(1, rd, v, 1, 0, 0, mdl_ovf));
        mdl[rd] = v; mdl_ovf = 1'b0;
      end
      3'd6: begin
        if (ins[12]) begin
          q.push_back(mk(1, rd, b, 0, 0, 0, mdl_ovf));
          q.push_back(mk(1, rt, o, 1, 0, 0, mdl_ovf));
          mdl[rd] = b; mdl[rt] = o;
        end else begin
          q.push_back(mk(1, rd, b, 1, 0, 0, mdl_ovf));
          mdl[rd] = b;
        end
        mdl_ovf = 1'b0;
      end
      default: q.push_back(mk(0, 0, 0, 0, 1, 0, mdl_ovf));
    endcase
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = '0;
    bnd = 0;
    while (q.size() != 0 && bnd < 8) begin
      @(posedge clk); #1;
      bnd++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin rf[i] = '0; mdl[i] = '0; end
    #1;
    chk("reset instr_ready", instr_ready, 0);
    chk("reset rf_we", rf_we, 0);
    chk("reset done", done, 0);
    chk("reset ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    setr(1, 16'd7); setr(2, 16'd5);
    issue(16'h0312);
    chk("ADD r3", rf[3], 16'd12);
    chk("ADD ovf", ovf, 0);
    setr(1, 16'd300); setr(2, 16'hFF38);
    issue(16'h4412);
    chk("MUL r4", rf[4], 16'h15A0);
    chk("MUL r15", rf[15], 16'hFFFF);
    setr(1, 16'd17); setr(2, 16'd5);
    issue(16'h6612);
    chk("DIV r6", rf[6], 16'd3);
    chk("DIV r15", rf[15], 16'd2);
    setr(2, 16'd0);
    issue(16'h6712);
    chk("DIV0 r7", rf[7], 16'd0);
    setr(5, 16'hAAAA); setr(6, 16'h5555);
    issue(16'hD506);
    chk("SWP r5", rf[5], 16'h5555);
    chk("SWP r6", rf[6], 16'hAAAA);
    issue(16'h850F);
    chk("ANDI r5", rf[5], 16'h0005);
    setr(1, 16'h8000); setr(2, 16'h8000);
    issue(16'h0712);
    chk("ADD wrap r7", rf[7], 16'h0000);
    chk("ADD carry ovf", ovf, 1);
    issue(16'hE912);
    chk("ILL keeps ovf", ovf, 1);
    issue(16'h2812);
    chk("SUB clears ovf", ovf, 0);
    issue(16'hCA01);
    chk("MOV r10", rf[10], 16'h8000);
    setr(11, 16'h1200);
    issue(16'hAB3C);
    chk("ORI r11", rf[11], 16'h123C);
    setr(1, 16'd3); setr(2, 16'd4);
    issue(16'h4F12);
    chk("MUL rd=HI r15", rf[15], 16'h0000);
    setr(3, 16'h0BEE);
    issue(16'hD303);
    chk("SWP rd=rt r3", rf[3], 16'h0BEE);
    setr(1, 16'h8000); setr(2, 16'h8000);
    issue(16'h0712);
    chk_en = 1'b0;
    setr(1, 16'd300); setr(2, 16'hFF38); setr(15, 16'h1234);
    old15 = rf[15];
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = 16'h4412;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = '0;
    @(posedge clk); #1;
    chk("WR2 rf_wa", rf_wa, 15);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rf_we", rf_we, 0);
    chk("async rst done", done, 0);
    chk("async rst err", err, 0);
    chk("async rst ovf", ovf, 0);
    chk("async rst ready", instr_ready, 0);
    chk("async rst alu_op", alu_op, 0);
    chk("async rst alu_a", alu_a, 0);
    chk("async rst rf_wd", rf_wd, 0);
    @(posedge clk); #1;
    chk("abort r15", rf[15], old15);
    chk("abort r4", rf[4], 16'h15A0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst ready", instr_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
